// File: rtl/kitt_scanner.sv
// Knight-Rider style LED scanner: a prescaled head walks the LED bar in one of four
// motion modes, followed by a PWM-dimmed trail of its most recent positions.
module kitt_scanner #(
  parameter int          N_LEDS   = 16,
  parameter int unsigned PRESCALE = 33554432,
  parameter int          TRAIL    = 3,
  parameter int          PWM_BITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [1:0]                speed,
  output logic [N_LEDS-1:0]         led,
  output logic [$clog2(N_LEDS)-1:0] pos,
  output logic                      dir,
  output logic                      step
);

  localparam int                POS_W   = $clog2(N_LEDS);
  localparam int                TRAIL_A = (TRAIL > 0) ? TRAIL : 1;
  localparam logic [31:0]       PRE     = PRESCALE;
  localparam logic [POS_W-1:0]  POS_MAX = POS_W'(N_LEDS - 1);

  localparam logic [1:0] MODE_BOUNCE = 2'b00;
  localparam logic [1:0] MODE_ROT_R  = 2'b01;
  localparam logic [1:0] MODE_ROT_L  = 2'b10;

  // Duty (in PWM counts) of history entry k: full scale halved per age step.
  function automatic logic [PWM_BITS:0] duty_of(input int k);
    logic [PWM_BITS:0] full;
    full           = '0;
    full[PWM_BITS] = 1'b1;
    return full >> k;
  endfunction

  logic [31:0]                     r_cnt;
  logic [PWM_BITS-1:0]             r_pwm_cnt;
  logic [POS_W-1:0]                r_pos;
  logic                            r_dir;
  logic                            r_step;
  logic [N_LEDS-1:0]               r_led;
  logic [TRAIL_A-1:0][POS_W-1:0]   r_hist;

  logic [31:0]                     w_term;
  logic                            w_tick;
  logic                            w_shift;
  logic [POS_W-1:0]                w_pos_nxt;
  logic                            w_dir_nxt;
  logic [TRAIL_A:0][N_LEDS-1:0]    w_acc;
  logic [N_LEDS-1:0]               w_led;

  // Using >= lets a speed-up that lands the count above the new terminal fire at once.
  assign w_term  = (PRE >> speed) - 32'd1;
  assign w_tick  = en && (r_cnt >= w_term);
  assign w_shift = w_tick && (w_pos_nxt != r_pos);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (en) begin
      if (w_tick) r_cnt <= '0;
      else        r_cnt <= r_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm_cnt <= '0;
    else        r_pwm_cnt <= r_pwm_cnt + 1'b1;
  end

  // Mode is consulted only here, so it is effectively sampled on step cycles.
  always_comb begin
    w_pos_nxt = r_pos;
    w_dir_nxt = r_dir;
    case (mode)
      MODE_BOUNCE: begin
        if (r_dir) begin
          if (r_pos == '0) w_dir_nxt = 1'b0;
          else             w_pos_nxt = r_pos - 1'b1;
        end else begin
          if (r_pos == POS_MAX) w_dir_nxt = 1'b1;
          else                  w_pos_nxt = r_pos + 1'b1;
        end
      end
      MODE_ROT_R: begin
        w_dir_nxt = 1'b1;
        w_pos_nxt = (r_pos == '0) ? POS_MAX : r_pos - 1'b1;
      end
      MODE_ROT_L: begin
        w_dir_nxt = 1'b0;
        w_pos_nxt = (r_pos == POS_MAX) ? '0 : r_pos + 1'b1;
      end
      default: begin
        w_pos_nxt = r_pos;
        w_dir_nxt = r_dir;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos  <= POS_MAX;
      r_dir  <= 1'b1;
      r_step <= 1'b0;
    end else begin
      r_step <= w_tick;
      if (w_tick) begin
        r_pos <= w_pos_nxt;
        r_dir <= w_dir_nxt;
      end
    end
  end

  // Trail history only ages when the head actually moves (dwell/hold keep it).
  if (TRAIL_A == 1) begin : g_hist_one
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_hist <= POS_MAX;
      else if (w_shift) r_hist <= r_pos;
    end
  end else begin : g_hist_many
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_hist <= {TRAIL_A{POS_MAX}};
      else if (w_shift) r_hist <= {r_hist[TRAIL_A-2:0], r_pos};
    end
  end

  // Nested duty thresholds make an OR of coincident entries equal the brightest one.
  assign w_acc[0] = '0;
  for (genvar k = 0; k < TRAIL_A; k++) begin : g_trail
    logic [N_LEDS-1:0] w_mask;
    always_comb begin
      w_mask = '0;
      if ((k < TRAIL) && ({1'b0, r_pwm_cnt} < duty_of(k + 1)))
        w_mask[r_hist[k]] = 1'b1;
    end
    assign w_acc[k+1] = w_acc[k] | w_mask;
  end

  always_comb begin
    w_led        = w_acc[TRAIL_A];
    w_led[r_pos] = 1'b1;
  end

  // Output register stage: led lags the head/history/pwm state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led         <= '0;
      r_led[N_LEDS-1] <= 1'b1;
    end else begin
      r_led <= w_led;
    end
  end

  assign led  = r_led;
  assign pos  = r_pos;
  assign dir  = r_dir;
  assign step = r_step;

endmodule
